// File: rtl/reg_list_sequencer.sv
// reg_list_sequencer: expands PUSH/POP/STM/LDM register lists into one
// memory micro-op per register, followed by a single base-writeback pulse.
module reg_list_sequencer #(
    parameter int ADDR_WIDTH = 4,
    parameter int LIST_WIDTH = 8,
    parameter int SP_REG_NUM = 13,
    parameter int LR_REG_NUM = 14,
    parameter int PC_REG_NUM = 15,
    parameter int OFF_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [ADDR_WIDTH-1:0] base_reg_i,
    input  logic [LIST_WIDTH-1:0] reg_list_i,
    input  logic                  extra_i,
    output logic                  ready_o,
    output logic                  stall_o,
    output logic                  uop_valid_o,
    input  logic                  uop_ready_i,
    output logic [ADDR_WIDTH-1:0] uop_reg_o,
    output logic [ADDR_WIDTH-1:0] uop_base_o,
    output logic [OFF_WIDTH-1:0]  uop_off_o,
    output logic                  uop_load_o,
    output logic                  uop_last_o,
    output logic                  wb_valid_o,
    output logic [ADDR_WIDTH-1:0] wb_reg_o,
    output logic [OFF_WIDTH-1:0]  wb_delta_o,
    output logic                  err_o
);
    // Internal list spans the whole register file so LR/PC can be appended.
    localparam int RW = 1 << ADDR_WIDTH;
    localparam int CW = $clog2(RW + 1);

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_LDM  = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [RW-1:0]         list_q, list_d;
    logic [CW-1:0]         n_q, n_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [OFF_WIDTH-1:0]  off_q, off_d;
    logic                  wb_en_q, wb_en_d;
    logic                  err_q, err_d;

    logic [RW-1:0]         eff_list;
    logic [CW-1:0]         eff_cnt;
    logic [ADDR_WIDTH-1:0] cur_reg;
    logic [OFF_WIDTH-1:0]  four_n;
    logic                  issuing;
    logic                  wb_fire;

    // Effective list (with LR/PC appended) and its population count.
    always_comb begin
        eff_list = '0;
        eff_list[LIST_WIDTH-1:0] = reg_list_i;
        if (extra_i && op_i == OP_PUSH) eff_list[LR_REG_NUM] = 1'b1;
        if (extra_i && op_i == OP_POP)  eff_list[PC_REG_NUM] = 1'b1;
        eff_cnt = '0;
        for (int i = 0; i < RW; i++) eff_cnt = eff_cnt + CW'(eff_list[i]);
    end

    // Lowest remaining register is the one currently presented.
    always_comb begin
        cur_reg = '0;
        for (int i = RW - 1; i >= 0; i--)
            if (list_q[i]) cur_reg = ADDR_WIDTH'(i);
    end

    // Next-state logic: latch on start, retire one register per handshake.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        base_d  = base_q;
        list_d  = list_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        wb_en_d = wb_en_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d    = op_i;
                    base_d  = (op_i == OP_PUSH || op_i == OP_POP) ?
                              ADDR_WIDTH'(SP_REG_NUM) : base_reg_i;
                    list_d  = eff_list;
                    n_d     = eff_cnt;
                    cnt_d   = eff_cnt;
                    off_d   = (op_i == OP_PUSH) ? -(OFF_WIDTH'(eff_cnt) << 2) : '0;
                    // A loaded base value overrides the writeback.
                    wb_en_d = !(op_i == OP_LDM && eff_list[base_reg_i]);
                    if (eff_cnt == '0) err_d = 1'b1;
                    else               state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (uop_ready_i) begin
                    list_d[cur_reg] = 1'b0;
                    off_d = off_q + OFF_WIDTH'(4);
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = WB;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            base_q  <= '0;
            list_q  <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            off_q   <= '0;
            wb_en_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            base_q  <= base_d;
            list_q  <= list_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            wb_en_q <= wb_en_d;
            err_q   <= err_d;
        end
    end

    // Outputs are zeroed whenever their qualifying valid is low.
    always_comb begin
        issuing     = (state_q == ISSUE);
        wb_fire     = (state_q == WB) && wb_en_q;
        four_n      = OFF_WIDTH'(n_q) << 2;
        ready_o     = (state_q == IDLE);
        stall_o     = (state_q != IDLE);
        uop_valid_o = issuing;
        uop_reg_o   = issuing ? cur_reg : '0;
        uop_base_o  = issuing ? base_q : '0;
        uop_off_o   = issuing ? off_q : '0;
        uop_load_o  = issuing && op_q[0];
        uop_last_o  = issuing && (cnt_q == CW'(1));
        wb_valid_o  = wb_fire;
        wb_reg_o    = wb_fire ? base_q : '0;
        wb_delta_o  = wb_fire ? ((op_q == OP_PUSH) ? -four_n : four_n) : '0;
        err_o       = err_q;
    end
endmodule

// File: tb/tb_reg_list_sequencer.sv
// Scoreboard bench for reg_list_sequencer: expected micro-ops and writebacks
// are queued when an instruction is driven and popped as the DUT emits them.
module tb_reg_list_sequencer;
    logic       clk_i = 1'b0;
    logic       rst_n_i, start_i, extra_i, uop_ready_i;
    logic [1:0] op_i;
    logic [3:0] base_reg_i;
    logic [7:0] reg_list_i;
    logic       ready_o, stall_o, uop_valid_o, uop_load_o, uop_last_o;
    logic       wb_valid_o, err_o;
    logic [3:0] uop_reg_o, uop_base_o, wb_reg_o;
    logic [7:0] uop_off_o, wb_delta_o;

    typedef struct {logic [3:0] r; logic [3:0] b; logic [7:0] off; logic ld; logic last;} uop_t;
    typedef struct {logic [3:0] r; logic [7:0] d;} wb_t;
    uop_t uq[$];
    wb_t  wq[$];
    int   passed = 0;
    int   total  = 0;
    logic err_allowed = 1'b0;
    logic mon_en = 1'b1;

    reg_list_sequencer dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .op_i(op_i),
        .base_reg_i(base_reg_i), .reg_list_i(reg_list_i), .extra_i(extra_i),
        .ready_o(ready_o), .stall_o(stall_o), .uop_valid_o(uop_valid_o),
        .uop_ready_i(uop_ready_i), .uop_reg_o(uop_reg_o), .uop_base_o(uop_base_o),
        .uop_off_o(uop_off_o), .uop_load_o(uop_load_o), .uop_last_o(uop_last_o),
        .wb_valid_o(wb_valid_o), .wb_reg_o(wb_reg_o), .wb_delta_o(wb_delta_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: build the expected micro-op/writeback stream.
    task automatic expect_op(input logic [1:0] op, input logic [3:0] base,
                             input logic [7:0] list, input logic extra);
        logic [15:0] eff;
        int n, rem, off;
        logic [3:0] b;
        uop_t u;
        wb_t  w;
        eff = {8'h00, list};
        if (extra && op == 2'd0) eff[14] = 1'b1;
        if (extra && op == 2'd1) eff[15] = 1'b1;
        n = 0;
        for (int i = 0; i < 16; i++) if (eff[i]) n++;
        b = (op <= 2'd1) ? 4'd13 : base;
        off = (op == 2'd0) ? -4 * n : 0;
        rem = n;
        for (int i = 0; i < 16; i++) begin
            if (eff[i]) begin
                u.r = 4'(i); u.b = b; u.off = 8'(off);
                u.ld = op[0]; u.last = (rem == 1);
                uq.push_back(u);
                off += 4; rem--;
            end
        end
        if (n > 0 && !(op == 2'd3 && eff[base])) begin
            w.r = b; w.d = (op == 2'd0) ? 8'(-4 * n) : 8'(4 * n);
            wq.push_back(w);
        end
    endtask

    // Monitor: compare every emitted micro-op and writeback against the queues.
    always @(negedge clk_i) begin
        if (mon_en && rst_n_i) begin
            if (uop_valid_o && uop_ready_i) begin
                total++;
                if (uq.size() == 0) begin
                    $display("FAIL uop_unexpected: got r%0d off=%0d, none required", uop_reg_o, $signed(uop_off_o));
                end else begin
                    uop_t e;
                    e = uq.pop_front();
                    if (uop_reg_o !== e.r || uop_base_o !== e.b || uop_off_o !== e.off ||
                        uop_load_o !== e.ld || uop_last_o !== e.last)
                        $display("FAIL uop: got r%0d b%0d off=%0d ld=%0b last=%0b, required r%0d b%0d off=%0d ld=%0b last=%0b",
                                 uop_reg_o, uop_base_o, $signed(uop_off_o), uop_load_o, uop_last_o,
                                 e.r, e.b, $signed(e.off), e.ld, e.last);
                    else passed++;
                end
            end
            if (wb_valid_o) begin
                total++;
                if (wq.size() == 0) begin
                    $display("FAIL wb_unexpected: got r%0d delta=%0d, none required", wb_reg_o, $signed(wb_delta_o));
                end else begin
                    wb_t e;
                    e = wq.pop_front();
                    if (wb_reg_o !== e.r || wb_delta_o !== e.d)
                        $display("FAIL wb: got r%0d delta=%0d, required r%0d delta=%0d",
                                 wb_reg_o, $signed(wb_delta_o), e.r, $signed(e.d));
                    else passed++;
                end
            end
            if (err_o && !err_allowed) begin
                total++;
                $display("FAIL err_unexpected: err_o=1, required 0");
            end
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [3:0] base,
                            input logic [7:0] list, input logic extra);
        expect_op(op, base, list, extra);
        @(posedge clk_i); #1;
        start_i = 1'b1; op_i = op; base_reg_i = base; reg_list_i = list; extra_i = extra;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while ((uq.size() != 0 || wq.size() != 0 || !ready_o) && cyc < 100) begin
            @(posedge clk_i); #1; cyc++;
        end
        total++;
        if (uq.size() != 0 || wq.size() != 0 || !ready_o)
            $display("FAIL %s_timeout: %0d uops and %0d wbs left, ready=%0b, required all drained",
                     name, uq.size(), wq.size(), ready_o);
        else passed++;
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; start_i = 0; op_i = 0; base_reg_i = 0; reg_list_i = 0;
        extra_i = 0; uop_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        total++;
        if (ready_o !== 1'b1 || stall_o !== 1'b0 || uop_valid_o !== 1'b0 ||
            wb_valid_o !== 1'b0 || err_o !== 1'b0 || uop_off_o !== 8'd0 || wb_delta_o !== 8'd0)
            $display("FAIL reset_outputs: ready=%0b stall=%0b uv=%0b wb=%0b err=%0b, required ready=1 rest 0",
                     ready_o, stall_o, uop_valid_o, wb_valid_o, err_o);
        else passed++;
        rst_n_i = 1'b1;
    endtask

    task automatic test_push();
        uop_ready_i = 1'b1;
        start_op(2'd0, 4'd0, 8'b0000_0101, 1'b1);
        total++;
        if (uop_valid_o !== 1'b1 || stall_o !== 1'b1 || ready_o !== 1'b0)
            $display("FAIL push_latency: uv=%0b stall=%0b ready=%0b, required 1 1 0", uop_valid_o, stall_o, ready_o);
        else passed++;
        wait_done("push");
    endtask

    task automatic test_pop_backpressure();
        uop_ready_i = 1'b0;
        start_op(2'd1, 4'd0, 8'b1000_0000, 1'b1);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (uop_valid_o !== 1'b1 || uop_reg_o !== 4'd7 || uop_off_o !== 8'd0 || uop_last_o !== 1'b0)
                $display("FAIL pop_hold: uv=%0b r%0d off=%0d last=%0b, required 1 r7 0 0",
                         uop_valid_o, uop_reg_o, $signed(uop_off_o), uop_last_o);
            else passed++;
            @(posedge clk_i); #1;
        end
        uop_ready_i = 1'b1;
        wait_done("pop");
    endtask

    task automatic test_ldm_base_in_list();
        uop_ready_i = 1'b1;
        start_op(2'd3, 4'd3, 8'b0000_1010, 1'b0);
        wait_done("ldm");
    endtask

    task automatic test_empty_list();
        @(posedge clk_i); #1;
        start_i = 1'b1; op_i = 2'd2; base_reg_i = 4'd0; reg_list_i = 8'h00; extra_i = 1'b1;
        err_allowed = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        total++;
        if (err_o !== 1'b1 || ready_o !== 1'b1 || uop_valid_o !== 1'b0)
            $display("FAIL empty_err: err=%0b ready=%0b uv=%0b, required 1 1 0", err_o, ready_o, uop_valid_o);
        else passed++;
        @(posedge clk_i); #1;
        err_allowed = 1'b0;
        total++;
        if (err_o !== 1'b0 || ready_o !== 1'b1)
            $display("FAIL empty_pulse: err=%0b ready=%0b, required 0 1", err_o, ready_o);
        else passed++;
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset_midstream();
        uop_ready_i = 1'b1;
        start_op(2'd2, 4'd0, 8'hFF, 1'b0);
        @(posedge clk_i); #1;
        total++;
        if (uop_reg_o !== 4'd1)
            $display("FAIL mid_second_uop: got r%0d, required r1", uop_reg_o);
        else passed++;
        rst_n_i = 1'b0;
        @(posedge clk_i); #1;
        uq.delete(); wq.delete();
        total++;
        if (ready_o !== 1'b1 || stall_o !== 1'b0 || uop_valid_o !== 1'b0 || uop_reg_o !== 4'd0 ||
            uop_off_o !== 8'd0 || wb_valid_o !== 1'b0 || err_o !== 1'b0)
            $display("FAIL mid_reset: ready=%0b stall=%0b uv=%0b r%0d off=%0d wb=%0b, required ready=1 rest 0",
                     ready_o, stall_o, uop_valid_o, uop_reg_o, $signed(uop_off_o), wb_valid_o);
        else passed++;
        rst_n_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        start_op(2'd0, 4'd0, 8'b0000_0011, 1'b0);
        wait_done("post_reset_push");
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        uop_ready_i = 1'b1;
        expect_op(2'd2, 4'd2, 8'b0001_0001, 1'b0);
        @(posedge clk_i); #1;
        start_i = 1'b1; op_i = 2'd2; base_reg_i = 4'd2; reg_list_i = 8'b0001_0001; extra_i = 1'b0;
        @(posedge clk_i); #1;
        op_i = 2'd0; reg_list_i = 8'hFF; extra_i = 1'b1;
        while (!ready_o && cyc < 50) begin
            @(posedge clk_i); #1; cyc++;
        end
        start_i = 1'b0;
        total++;
        if (!ready_o)
            $display("FAIL b2b_timeout: ready=%0b, required 1", ready_o);
        else passed++;
        wait_done("b2b");
    endtask

    initial begin
        test_reset();
        test_push();
        test_pop_backpressure();
        test_ldm_base_in_list();
        test_empty_list();
        test_reset_midstream();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
